multicycle_controller: RTL and testbench

- Control FSM for the multicycle RV32I datapath. It replaces the single-cycle opcode-to-controls lookup with a sequenced Moore machine.
- Takes the latched instruction opcode, a memory ready handshake and the branch comparator result. Drives per-cycle mux selects, write enables and an illegal-instruction flag.
- Sits between the instruction register and the shared datapath: one ALU, one unified memory port, and ALUOut/Data/OldPC registers.
- ALUOp still feeds the existing ALU decoder.

---
 rtl/rv_ctrl_pkg.sv | 56 +++++
 rtl/imm_src_decode.sv | 20 ++
 rtl/multicycle_controller.sv | 175 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared opcodes, state encoding and control-field encodings for the
// multicycle RV32I control path.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_UPPER     = 4'd13,
    S_ILLEGAL   = 4'd14
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_src_decode.sv
// Opcode to immediate-format select; purely combinational, valid in every state.
module imm_src_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:          imm_src = IMM_S;
      OP_BRANCH:         imm_src = IMM_B;
      OP_JAL:            imm_src = IMM_J;
      OP_LUI, OP_AUIPC:  imm_src = IMM_U;
      default:           imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequenced Moore control for the multicycle RV32I datapath: state register,
// per-state output decode and the sticky illegal-opcode flag.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC + 4 when memory completes
// DECODE     | ALUOut <= OldPC + imm (branch/jal target)
// MEMADR     | ALUOut <= rs1 + imm
// MEMREAD    | read data at ALUOut, wait for memory
// MEMWB      | rd <= Data
// MEMWRITE   | write rs2 at ALUOut, wait for memory
// EXEC_R     | ALUOut <= rs1 op rs2
// EXEC_I     | ALUOut <= rs1 op imm
// ALUWB      | rd <= ALUOut
// BRANCH     | compare, PC <= ALUOut if taken
// JAL        | PC <= target, ALUOut <= OldPC + 4
// JALR       | PC <= rs1 + imm
// JALR_LINK  | rd <= OldPC + 4
// UPPER      | ALUOut <= imm (lui) or OldPC + imm (auipc)
// ILLEGAL    | stop, wait for reset
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter bit HAS_UPPER     = 1'b1,
  parameter bit HAS_JALR      = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  state_t state;
  state_t next_state;
  logic   mem_done;

  assign mem_done = MEM_HANDSHAKE ? mem_ready : 1'b1;

  imm_src_decode u_imm_src_decode (
    .op      (op),
    .imm_src (ImmSrc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_ILLEGAL) illegal <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_done) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = HAS_JALR ? S_JALR : S_ILLEGAL;
          OP_LUI, OP_AUIPC:  next_state = HAS_UPPER ? S_UPPER : S_ILLEGAL;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:    next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:   if (mem_done) next_state = S_MEMWB;
      S_MEMWB:     next_state = S_FETCH;
      S_MEMWRITE:  if (mem_done) next_state = S_FETCH;
      S_EXEC_R:    next_state = S_ALUWB;
      S_EXEC_I:    next_state = S_ALUWB;
      S_ALUWB:     next_state = S_FETCH;
      S_BRANCH:    next_state = S_FETCH;
      S_JAL:       next_state = S_ALUWB;
      S_JALR:      next_state = S_JALR_LINK;
      S_JALR_LINK: next_state = S_FETCH;
      S_UPPER:     next_state = S_ALUWB;
      S_ILLEGAL:   next_state = S_ILLEGAL;
      default:     next_state = S_FETCH;
    endcase
  end

  // Memory and register-file writes are suppressed while reset is held so
  // an interrupted access cannot complete on the reset edge.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_done;
        PCWrite   = mem_done;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = ~reset;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = ~reset;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = ~reset;
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_BRANCH;
        PCWrite = branch_taken;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
      end
      S_JALR_LINK: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        RegWrite  = ~reset;
      end
      S_UPPER: begin
        ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: latency table, per-cycle trace model,
// reset-in-flight sequences and random instruction streams on two builds.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [2:0] imm;
    logic       ill;
  } outs_t;

  typedef struct {
    logic  mr;
    logic  bt;
    outs_t exp;
  } step_t;

  typedef struct {
    logic [6:0] op;
    int         fw;
    int         mw;
    logic       bt;
    int         cyc;
    int         regw;
    int         memw;
    int         pcw;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_a, reset_b;
  logic [6:0] op;
  logic       mem_ready, branch_taken;

  logic       pcw_a, adr_a, memw_a, irw_a, regw_a, ill_a;
  logic [1:0] res_a, srca_a, srcb_a, aluop_a;
  logic [2:0] imm_a;
  logic       pcw_b, adr_b, memw_b, irw_b, regw_b, ill_b;
  logic [1:0] res_b, srca_b, srcb_b, aluop_b;
  logic [2:0] imm_b;
  outs_t      o_a, o_b;

  always #5 clk = ~clk;

  multicycle_controller dut_a (
    .clk(clk), .reset(reset_a), .op(op), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(memw_a), .IRWrite(irw_a), .RegWrite(regw_a),
    .ResultSrc(res_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a), .ALUOp(aluop_a), .ImmSrc(imm_a),
    .illegal(ill_a)
  );

  multicycle_controller #(.HAS_UPPER(1'b0), .HAS_JALR(1'b0), .MEM_HANDSHAKE(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .op(op), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(memw_b), .IRWrite(irw_b), .RegWrite(regw_b),
    .ResultSrc(res_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b), .ALUOp(aluop_b), .ImmSrc(imm_b),
    .illegal(ill_b)
  );

  assign o_a = {pcw_a, adr_a, memw_a, irw_a, regw_a, res_a, srca_a, srcb_a, aluop_a, imm_a, ill_a};
  assign o_b = {pcw_b, adr_b, memw_b, irw_b, regw_b, res_b, srca_b, srcb_b, aluop_b, imm_b, ill_b};

  int    n_checks = 0;
  int    n_fail   = 0;
  step_t q[$];
  vec_t  tbl_a[10];
  vec_t  tbl_b[4];

  function automatic outs_t cur(input bit sel);
    return sel ? o_b : o_a;
  endfunction

  task automatic check_outs(input string name, input outs_t act, input outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pcw%b adr%b memw%b irw%b regw%b res%b srca%b srcb%b aluop%b imm%b ill%b, expected pcw%b adr%b memw%b irw%b regw%b res%b srca%b srcb%b aluop%b imm%b ill%b",
               name, act.pcw, act.adr, act.memw, act.irw, act.regw, act.res, act.srca, act.srcb,
               act.aluop, act.imm, act.ill, exp.pcw, exp.adr, exp.memw, exp.irw, exp.regw,
               exp.res, exp.srca, exp.srcb, exp.aluop, exp.imm, exp.ill);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic outs_t base(input logic [6:0] o);
    outs_t e = '0;
    e.imm = imm_of(o);
    return e;
  endfunction

  function automatic bit is_fetch(input outs_t ob);
    return ob.srca == 2'b00 && ob.srcb == 2'b10 && ob.res == 2'b10 && ob.aluop == 2'b00 && !ob.adr;
  endfunction

  task automatic push(input logic mr, input logic bt, input outs_t e);
    step_t s;
    s.mr = mr; s.bt = bt; s.exp = e;
    q.push_back(s);
  endtask

  task automatic push_aluwb(input logic [6:0] o);
    outs_t e = base(o);
    e.regw = 1'b1;
    push(rbit(), rbit(), e);
  endtask

  // Expected per-cycle trace of one instruction, starting in FETCH.
  task automatic build(input logic [6:0] o, input int fw, input int mw, input logic bt,
                       input bit up, input bit jr, input bit hs, output bit ill);
    outs_t e;
    ill = 1'b0;
    if (hs) repeat (fw) begin
      e = base(o); e.srcb = 2'b10; e.res = 2'b10;
      push(1'b0, rbit(), e);
    end
    e = base(o); e.srcb = 2'b10; e.res = 2'b10; e.irw = 1'b1; e.pcw = 1'b1;
    push(hs ? 1'b1 : (fw == 0), rbit(), e);
    e = base(o); e.srca = 2'b01; e.srcb = 2'b01;
    push(rbit(), rbit(), e);
    case (o)
      7'b0000011, 7'b0100011: begin
        e = base(o); e.srca = 2'b10; e.srcb = 2'b01;
        push(rbit(), rbit(), e);
        e = base(o); e.adr = 1'b1; e.memw = o[5];
        if (hs) repeat (mw) push(1'b0, rbit(), e);
        push(hs ? 1'b1 : (mw == 0), rbit(), e);
        if (!o[5]) begin
          e = base(o); e.res = 2'b01; e.regw = 1'b1;
          push(rbit(), rbit(), e);
        end
      end
      7'b0110011, 7'b0010011: begin
        e = base(o); e.srca = 2'b10; e.aluop = 2'b10; e.srcb = o[5] ? 2'b00 : 2'b01;
        push(rbit(), rbit(), e);
        push_aluwb(o);
      end
      7'b1100011: begin
        e = base(o); e.srca = 2'b10; e.aluop = 2'b01; e.pcw = bt;
        push(rbit(), bt, e);
      end
      7'b1101111: begin
        e = base(o); e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1;
        push(rbit(), rbit(), e);
        push_aluwb(o);
      end
      7'b1100111: begin
        if (jr) begin
          e = base(o); e.srca = 2'b10; e.srcb = 2'b01; e.res = 2'b10; e.pcw = 1'b1;
          push(rbit(), rbit(), e);
          e = base(o); e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10; e.regw = 1'b1;
          push(rbit(), rbit(), e);
        end else ill = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        if (up) begin
          e = base(o); e.srca = o[5] ? 2'b11 : 2'b01; e.srcb = 2'b01;
          push(rbit(), rbit(), e);
          push_aluwb(o);
        end else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) repeat (3) begin
      e = base(o); e.ill = 1'b1;
      push(rbit(), rbit(), e);
    end
  endtask

  task automatic apply(input bit sel, input int n);
    int lim = (n < 0) ? q.size() : n;
    for (int i = 0; i < lim; i++) begin
      mem_ready    = q[i].mr;
      branch_taken = q[i].bt;
      @(negedge clk);
      check_outs($sformatf("%s op%b step%0d", sel ? "b" : "a", op, i), cur(sel), q[i].exp);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input bit sel, input bit hs);
    outs_t e;
    if (sel) reset_b = 1'b1; else reset_a = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    e = base(op); e.srcb = 2'b10; e.res = 2'b10; e.irw = !hs; e.pcw = !hs;
    @(negedge clk);
    check_outs(sel ? "reset_state_b" : "reset_state_a", cur(sel), e);
    @(posedge clk); #1;
    if (sel) reset_b = 1'b0; else reset_a = 1'b0;
  endtask

  task automatic run_instr(input bit sel, input logic [6:0] o, input int fw, input int mw,
                           input logic bt, input bit up, input bit jr, input bit hs);
    bit ill;
    q.delete();
    op = o;
    build(o, fw, mw, bt, up, jr, hs, ill);
    apply(sel, -1);
    if (ill) do_reset(sel, hs);
  endtask

  // Drives memory waits reactively from the DUT's own address select and
  // measures latency until the DUT is back in FETCH.
  task automatic run_vec(input bit sel, input vec_t v);
    int    fwc = v.fw, mwc = v.mw, cyc = 0, rw = 0, mwn = 0, pw = 0;
    bit    done = 1'b0, prevf = 1'b0, f;
    outs_t ob;
    op = v.op;
    branch_taken = v.bt;
    for (int t = 0; t < 40 && !done; t++) begin
      ob = cur(sel);
      f  = is_fetch(ob);
      if (t > 0 && f && !prevf) done = 1'b1;
      else begin
        if (f) begin
          mem_ready = (fwc == 0);
          if (fwc > 0) fwc--;
        end else if (ob.adr) begin
          mem_ready = (mwc == 0);
          if (mwc > 0) mwc--;
        end else mem_ready = 1'b1;
        prevf = f;
        @(negedge clk);
        ob = cur(sel);
        cyc++;
        rw  += int'(ob.regw);
        mwn += int'(ob.memw);
        pw  += int'(ob.pcw);
        @(posedge clk); #1;
      end
    end
    check_int($sformatf("done op%b", v.op), int'(done), 1);
    check_int($sformatf("latency op%b", v.op), cyc, v.cyc);
    check_int($sformatf("regwrite_cycles op%b", v.op), rw, v.regw);
    check_int($sformatf("memwrite_cycles op%b", v.op), mwn, v.memw);
    check_int($sformatf("pcwrite_cycles op%b", v.op), pw, v.pcw);
  endtask

  task automatic reset_mid(input logic [6:0] o, input int n);
    bit    ill;
    outs_t e;
    q.delete();
    op = o;
    build(o, 0, 3, 1'b0, 1'b1, 1'b1, 1'b1, ill);
    apply(1'b0, n);
    e = q[n].exp; e.memw = 1'b0; e.regw = 1'b0;
    mem_ready = q[n].mr;
    reset_a = 1'b1;
    @(negedge clk);
    check_outs($sformatf("reset_in_flight op%b", o), o_a, e);
    @(posedge clk); #1;
    reset_a = 1'b0;
    mem_ready = 1'b0;
    e = base(o); e.srcb = 2'b10; e.res = 2'b10;
    @(negedge clk);
    check_outs($sformatf("after_reset op%b", o), o_a, e);
    @(posedge clk); #1;
  endtask

  task automatic rand_instr(input bit sel, input bit up, input bit jr, input bit hs);
    logic [6:0] ops[10];
    logic [6:0] o;
    int k;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
    k = $urandom_range(0, 12);
    o = (k < 10) ? ops[k] : 7'($urandom_range(0, 127));
    run_instr(sel, o, $urandom_range(0, 2), $urandom_range(0, 3), rbit(), up, jr, hs);
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    op = 7'b0110011; mem_ready = 1'b0; branch_taken = 1'b0;

    tbl_a[0] = '{7'b0110011, 0, 0, 1'b0, 4, 1, 0, 1};
    tbl_a[1] = '{7'b0000011, 0, 2, 1'b0, 7, 1, 0, 1};
    tbl_a[2] = '{7'b0100011, 0, 1, 1'b0, 5, 0, 2, 1};
    tbl_a[3] = '{7'b1100011, 0, 0, 1'b1, 3, 0, 0, 2};
    tbl_a[4] = '{7'b1100011, 0, 0, 1'b0, 3, 0, 0, 1};
    tbl_a[5] = '{7'b0010111, 0, 0, 1'b0, 4, 1, 0, 1};
    tbl_a[6] = '{7'b0110111, 0, 0, 1'b0, 4, 1, 0, 1};
    tbl_a[7] = '{7'b1100111, 0, 0, 1'b0, 4, 1, 0, 2};
    tbl_a[8] = '{7'b1101111, 1, 0, 1'b0, 5, 1, 0, 2};
    tbl_a[9] = '{7'b0010011, 2, 0, 1'b0, 6, 1, 0, 1};
    tbl_b[0] = '{7'b0000011, 1, 2, 1'b0, 5, 1, 0, 1};
    tbl_b[1] = '{7'b0100011, 2, 1, 1'b0, 4, 0, 1, 1};
    tbl_b[2] = '{7'b1100011, 0, 0, 1'b1, 3, 0, 0, 2};
    tbl_b[3] = '{7'b0110011, 1, 0, 1'b0, 4, 1, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, 1'b1);

    run_instr(1'b0, 7'b0110011, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    foreach (tbl_a[i]) run_vec(1'b0, tbl_a[i]);

    run_instr(1'b0, 7'b0000011, 0, 2, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr(1'b0, 7'b0100011, 0, 1, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr(1'b0, 7'b1100011, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    run_instr(1'b0, 7'b1100011, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr(1'b0, 7'b0010111, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr(1'b0, 7'b0110111, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr(1'b0, 7'b1100111, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_instr(1'b0, 7'b0000000, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);

    reset_mid(7'b0000011, 3);
    reset_mid(7'b0100011, 4);
    reset_mid(7'b0110011, 3);

    repeat (150) rand_instr(1'b0, 1'b1, 1'b1, 1'b1);

    reset_a = 1'b1;
    do_reset(1'b1, 1'b0);
    foreach (tbl_b[i]) run_vec(1'b1, tbl_b[i]);
    run_instr(1'b1, 7'b0010111, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b1, 7'b0110111, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b1, 7'b1100111, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (80) rand_instr(1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
